// File: rtl/sc_ifu.sv
// sc_ifu: instruction-fetch unit owning the PC, fetching over req/ack and issuing inst to the decoder
//   clock, resetn                  clock and synchronous active-low reset
//   pcsource, bpc, rpc, jpc        next-PC select and candidate targets
//   stall                          holds the issued instruction, blocking commit
//   imem_req/addr/ack/rdata        instruction memory handshake
//   inst, inst_valid, pc, pc4      issued instruction, its address and address+4
//   retired                        committed instruction count
//   fetch_err                      sticky watchdog error (fetch never acknowledged)
module sc_ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] retired,
    output logic        fetch_err
);
    typedef enum logic [1:0] {BOOT, FETCH, ISSUE, HALT} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [31:0] pc_nx, inst_nx, retired_nx, sel, npc;
    logic [15:0] wait_cnt, wait_nx;
    logic        err_nx;

    assign pc4       = pc + 32'd4;
    assign imem_addr = pc;
    assign sel = pcsource == 2'b00 ? pc4 :
                 pcsource == 2'b01 ? bpc :
                 pcsource == 2'b10 ? rpc : jpc;
    // targets are word aligned unconditionally, so a misaligned jr lands on the word below
    assign npc = sel & ~32'h3;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            inst      <= '0;
            retired   <= '0;
            fetch_err <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            inst      <= inst_nx;
            retired   <= retired_nx;
            fetch_err <= err_nx;
            wait_cnt  <= wait_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        inst_nx    = inst;
        retired_nx = retired;
        err_nx     = fetch_err;
        wait_nx    = wait_cnt;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        case (state)
            BOOT: state_nx = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    inst_nx  = imem_rdata;
                    wait_nx  = '0;
                    state_nx = ISSUE;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = HALT;
                end else begin
                    wait_nx = wait_cnt + 16'd1;
                end
            end
            ISSUE: begin
                inst_valid = 1'b1;
                if (!stall) begin
                    pc_nx      = npc;
                    retired_nx = retired + 32'd1;
                    state_nx   = FETCH;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sc_ifu.sv
// tb_sc_ifu: directed table-driven bench for sc_ifu plus multi-cycle corner sequences
module tb_sc_ifu;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = '0, rpc = '0, jpc = '0;
    logic        stall = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req, inst_valid, fetch_err;
    logic [31:0] imem_addr, inst, pc, pc4, retired;
    logic        u1_req, u1_valid, u1_err;
    logic [31:0] u1_addr, u1_inst, u1_pc, u1_pc4, u1_retired;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  psrc;
        logic [31:0] b, r, j, epc, epc4, enext;
    } vec_t;
    vec_t vt[10];

    sc_ifu dut (
        .clock(clock), .resetn(resetn), .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc4(pc4),
        .retired(retired), .fetch_err(fetch_err)
    );

    sc_ifu #(.TIMEOUT(1)) u1 (
        .clock(clock), .resetn(resetn), .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
        .stall(stall), .imem_req(u1_req), .imem_addr(u1_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(u1_inst), .inst_valid(u1_valid), .pc(u1_pc), .pc4(u1_pc4),
        .retired(u1_retired), .fetch_err(u1_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vt[0] = '{32'h2008_0005, 2'b00, 32'h0000_AAA0, 32'h0000_BBB0, 32'h0000_CCC0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0004};
        vt[1] = '{32'h0800_0004, 2'b11, 32'h0000_AAA0, 32'h0000_BBB0, 32'h0000_0010, 32'h0000_0004, 32'h0000_0008, 32'h0000_0010};
        vt[2] = '{32'h1000_000B, 2'b01, 32'h0000_0040, 32'h0000_BBB0, 32'h0000_CCC0, 32'h0000_0010, 32'h0000_0014, 32'h0000_0040};
        vt[3] = '{32'h0320_0008, 2'b10, 32'h0000_AAA0, 32'h0000_0013, 32'h0000_CCC0, 32'h0000_0040, 32'h0000_0044, 32'h0000_0010};
        vt[4] = '{32'h2129_0001, 2'b00, 32'h0000_AAA0, 32'h0000_BBB0, 32'h0000_CCC0, 32'h0000_0010, 32'h0000_0014, 32'h0000_0014};
        vt[5] = '{32'h03E0_0008, 2'b10, 32'h0000_AAA0, 32'h0000_0103, 32'h0000_CCC0, 32'h0000_0014, 32'h0000_0018, 32'h0000_0100};
        vt[6] = '{32'h0810_0000, 2'b11, 32'h0000_AAA0, 32'h0000_BBB0, 32'h0040_0000, 32'h0000_0100, 32'h0000_0104, 32'h0040_0000};
        vt[7] = '{32'h0340_0008, 2'b10, 32'h0000_AAA0, 32'hFFFF_FFFC, 32'h0000_CCC0, 32'h0040_0000, 32'h0040_0004, 32'hFFFF_FFFC};
        vt[8] = '{32'h0000_0020, 2'b00, 32'h0000_AAA0, 32'h0000_BBB0, 32'h0000_CCC0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
        vt[9] = '{32'h1421_0007, 2'b01, 32'h0000_0022, 32'h0000_BBB0, 32'h0000_CCC0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0020};

        // reset state
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc4, 32'h4);
        chk("rst_inst", inst, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_err", {31'b0, fetch_err}, 32'h0);
        resetn = 1'b1;
        // cycle 1 after release: BOOT
        chk("boot_req", {31'b0, imem_req}, 32'h0);
        tick();
        // cycle 2: FETCH at RESET_PC
        chk("c2_req", {31'b0, imem_req}, 32'h1);
        chk("c2_addr", imem_addr, 32'h0);

        for (int i = 0; i < 10; i++) begin
            imem_ack = 1'b1;
            imem_rdata = vt[i].rdata;
            tick();
            imem_ack = 1'b0;
            chk($sformatf("v%0d_inst", i), inst, vt[i].rdata);
            chk($sformatf("v%0d_valid", i), {31'b0, inst_valid}, 32'h1);
            chk($sformatf("v%0d_req_issue", i), {31'b0, imem_req}, 32'h0);
            chk($sformatf("v%0d_pc", i), pc, vt[i].epc);
            chk($sformatf("v%0d_pc4", i), pc4, vt[i].epc4);
            pcsource = vt[i].psrc;
            bpc = vt[i].b;
            rpc = vt[i].r;
            jpc = vt[i].j;
            tick();
            chk($sformatf("v%0d_next_addr", i), imem_addr, vt[i].enext);
            chk($sformatf("v%0d_req_fetch", i), {31'b0, imem_req}, 32'h1);
            chk($sformatf("v%0d_valid_fetch", i), {31'b0, inst_valid}, 32'h0);
            chk($sformatf("v%0d_retired", i), retired, 32'(i + 1));
        end

        // ack delayed 3 cycles: address stable for 4 FETCH cycles
        pcsource = 2'b00;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dly%0d_addr", i), imem_addr, 32'h20);
            chk($sformatf("dly%0d_req", i), {31'b0, imem_req}, 32'h1);
            tick();
            chk($sformatf("dly%0d_err", i), {31'b0, fetch_err}, 32'h0);
            if (i == 0) chk("t1_err", {31'b0, u1_err}, 32'h1);
        end
        chk("dly3_addr", imem_addr, 32'h20);
        imem_ack = 1'b1;
        imem_rdata = 32'h8C43_0004;
        tick();
        chk("dly_valid", {31'b0, inst_valid}, 32'h1);
        chk("dly_inst", inst, 32'h8C43_0004);
        chk("dly_err", {31'b0, fetch_err}, 32'h0);
        chk("t1_req", {31'b0, u1_req}, 32'h0);

        // stall 5 ISSUE cycles with a stray ack that must be ignored
        stall = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stl%0d_valid", i), {31'b0, inst_valid}, 32'h1);
            chk($sformatf("stl%0d_pc", i), pc, 32'h20);
            chk($sformatf("stl%0d_inst", i), inst, 32'h8C43_0004);
            chk($sformatf("stl%0d_retired", i), retired, 32'd10);
            tick();
        end
        stall = 1'b0;
        imem_ack = 1'b0;
        chk("stl_drop_valid", {31'b0, inst_valid}, 32'h1);
        tick();
        chk("stl_commit_pc", pc, 32'h24);
        chk("stl_commit_retired", retired, 32'd11);
        chk("stl_commit_req", {31'b0, imem_req}, 32'h1);

        // retired wrap
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0000;
        tick();
        imem_ack = 1'b0;
        stall = 1'b1;
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        #1;
        chk("wrap_pre", retired, 32'hFFFF_FFFF);
        stall = 1'b0;
        tick();
        chk("wrap_retired", retired, 32'h0);
        chk("wrap_pc", pc, 32'h28);

        // watchdog: no ack for exactly 16 FETCH cycles
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("wd%0d_req", i), {31'b0, imem_req}, 32'h1);
            chk($sformatf("wd%0d_err", i), {31'b0, fetch_err}, 32'h0);
            tick();
        end
        chk("wd_err", {31'b0, fetch_err}, 32'h1);
        chk("wd_req", {31'b0, imem_req}, 32'h0);
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("halt%0d_req", i), {31'b0, imem_req}, 32'h0);
            chk($sformatf("halt%0d_err", i), {31'b0, fetch_err}, 32'h1);
            chk($sformatf("halt%0d_valid", i), {31'b0, inst_valid}, 32'h0);
            chk($sformatf("halt%0d_pc", i), pc, 32'h28);
            chk($sformatf("halt%0d_inst", i), inst, 32'h0);
        end
        imem_ack = 1'b0;

        // reset mid-FETCH with a simultaneous ack
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("rst2_err", {31'b0, fetch_err}, 32'h0);
        tick();
        chk("rst2_fetch_req", {31'b0, imem_req}, 32'h1);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        resetn = 1'b0;
        tick();
        imem_ack = 1'b0;
        chk("rstmid_inst", inst, 32'h0);
        chk("rstmid_pc", pc, 32'h0);
        chk("rstmid_req", {31'b0, imem_req}, 32'h0);
        chk("rstmid_valid", {31'b0, inst_valid}, 32'h0);
        chk("rstmid_retired", retired, 32'h0);
        resetn = 1'b1;
        tick();
        chk("rstmid_refetch", {31'b0, imem_req}, 32'h1);
        chk("rstmid_addr", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sc_ifu.md
Name: sc_ifu

Overview:
- Instruction-fetch unit for the single-cycle CPU. Sits directly upstream of the control decoder: it owns the PC, fetches from instruction memory over a req/ack handshake, and presents `inst` to the decoder and datapath.
- Consumes the decoder's `pcsource` and the datapath-computed targets to select the next PC.
- Adds a fetch watchdog and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- TIMEOUT, 16, max cycles `imem_req` may stay unacknowledged before a fetch error; legal range 1..65535.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- pcsource  in  2  next-PC select from the control decoder: 00 pc+4, 01 branch target, 10 jr register, 11 jump target.
- bpc  in  32  branch target (pc4 + sext offset<<2) from the datapath.
- rpc  in  32  register value for jr.
- jpc  in  32  jump target {pc4[31:28], index, 2'b00}.
- stall  in  1  datapath hold; blocks commit while high.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_ack  in  1  memory acknowledge; `imem_rdata` valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- inst  out  32  registered instruction to the decoder and datapath.
- inst_valid  out  1  `inst` is current and may be executed.
- pc  out  32  address of `inst`.
- pc4  out  32  pc + 4.
- retired  out  32  count of committed instructions.
- fetch_err  out  1  sticky watchdog error.

Behaviour:
- Reset (resetn=0 at an edge) puts the block in BOOT and sets:
  - pc=RESET_PC, inst=0, inst_valid=0, imem_req=0
  - retired=0, fetch_err=0, wait counter=0
- Reset dominates in every state, including mid-fetch. `imem_req` drops at the first edge with resetn=0, and any ack in that cycle is ignored.
- States: BOOT, FETCH, ISSUE, HALT.
- BOOT:
  - Held for exactly one cycle after reset release, then → FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until ack.
  - On the edge with imem_ack=1: inst<=imem_rdata, wait counter<=0, → ISSUE.
  - Otherwise the wait counter increments. When the counter equals TIMEOUT-1 and ack is still 0: fetch_err<=1, imem_req<=0, → HALT.
  - With TIMEOUT=1, the first cycle without ack halts.
- ISSUE:
  - imem_req=0 and inst_valid=1.
  - The decoder drives `pcsource` combinationally from `inst` during this cycle.
  - If stall=1: hold all state; inst, pc and inst_valid are unchanged.
  - If stall=0 (commit): pc<=npc, retired<=retired+1, → FETCH.
  - inst_valid is 0 in FETCH, BOOT and HALT, so it is high exactly while in ISSUE.
- HALT:
  - Terminal; all outputs frozen except imem_req=0. Only reset exits.
- Imem_ack while not in FETCH is ignored.
- npc = {sel[31:2], 2'b00}, where sel is pc4/bpc/rpc/jpc chosen by pcsource. Low bits are forced to zero, so a misaligned jr target is silently aligned.
- Arithmetic:
  - pc4 = pc + 32'd4, modulo 2^32: pc=32'hFFFF_FFFC gives pc4=0.
  - retired wraps from 32'hFFFF_FFFF to 0.
- Latency:
  - Zero-wait memory (ack in the first FETCH cycle) gives 2 cycles per instruction: FETCH then ISSUE.
  - Each wait cycle adds 1.
  - The first inst_valid appears 3 cycles after resetn rises when ack is immediate.

Test Plan:
- Reset, then a zero-wait memory returning 32'h2008_0005 (addi) at address 0, then a stall-free commit → imem_addr=0 in cycle 2 after release, inst_valid in cycle 3, pc=4 and retired=1 after commit.
- Branch taken: inst at pc=0x10 with pcsource=01, bpc=0x40 → next imem_addr=0x40; with pcsource=00 → 0x14.
- jr with rpc=32'h0000_0103 → next fetch address 0x100; j with jpc=0x0040_0000 → next fetch address 0x0040_0000.
- Ack delayed 3 cycles with TIMEOUT=16 → imem_addr stable for 4 cycles and no error. Ack withheld entirely → fetch_err=1 after exactly 16 FETCH cycles, then imem_req=0 permanently until reset.
- stall held high for 5 ISSUE cycles → pc, inst and retired unchanged with inst_valid=1 throughout. Commit on the cycle stall drops.
- Reset asserted mid-FETCH with ack arriving in the same cycle → inst stays 0 and pc=RESET_PC. Wrap checks: pc=32'hFFFF_FFFC with pcsource=00 → next fetch address 0; retired preloaded near wrap rolls from 32'hFFFF_FFFF to 0.
